// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the two-source round-robin output mux.
package mux_arb_pkg;

    // Output register occupancy: EMPTY presents nothing, FULL presents out_data.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin grant: a lone requester always wins; on contention the
// requester named by prio wins. Purely combinational, one-hot (or zero) grant.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // Bit 0 is requester A, bit 1 is requester B; prio=1 favours B.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~prio);
        gnt[1] = req[1] & (~req[0] |  prio);
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Arbitrates two valid/ready sources into one registered output slot, with
// per-source saturating transfer counters.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_sel,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    state_t     state;
    logic       prio;
    logic       load;
    logic [1:0] gnt;
    logic       xfer_a;
    logic       xfer_b;
    logic       xfer;

    rr_pick2 u_pick (
        .req  ({b_valid, a_valid}),
        .prio (prio),
        .gnt  (gnt)
    );

    // The slot can take a word when empty, or when its current word leaves this cycle.
    always_comb begin
        out_valid = (state == FULL);
        load      = (state == EMPTY) || (out_valid && out_ready);
        // Readies are masked during reset so no transfer is counted or lost.
        a_ready   = load && gnt[0] && !rst;
        b_ready   = load && gnt[1] && !rst;
        xfer_a    = a_valid && a_ready;
        xfer_b    = b_valid && b_ready;
        xfer      = xfer_a || xfer_b;
    end

    // Output slot FSM, data/source capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= 1'b0;
            prio     <= 1'b0;
        end else if (xfer) begin
            state    <= FULL;
            out_data <= xfer_b ? b_data : a_data;
            out_sel  <= xfer_b;
            // Favour whichever side was not just served.
            prio     <= xfer_a;
        end else if (out_valid && out_ready) begin
            state    <= EMPTY;
        end
    end

    // Per-source transfer counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (xfer_a && (a_cnt != '1)) a_cnt <= a_cnt + 1'b1;
            if (xfer_b && (b_cnt != '1)) b_cnt <= b_cnt + 1'b1;
        end
    end

endmodule
